// File: rtl/sdet_param_if.sv
// rtl/sdet_param_if.sv - control, data and status bundle for the sequence detector
// Ports (master = stimulus side, slave = detector side):
//   en, cfg_load, cfg_pat, cfg_len, cfg_ovl, i, i_vld, cnt_clr : master -> slave
//   o, match_cnt, armed                                         : slave -> master
interface sdet_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               en;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               i;
    logic               i_vld;
    logic               cnt_clr;
    logic               o;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;

    modport master (
        output en, cfg_load, cfg_pat, cfg_len, cfg_ovl, i, i_vld, cnt_clr,
        input  o, match_cnt, armed
    );

    modport slave (
        input  en, cfg_load, cfg_pat, cfg_len, cfg_ovl, i, i_vld, cnt_clr,
        output o, match_cnt, armed
    );
endinterface

// File: rtl/sdet_param.sv
// rtl/sdet_param.sv - runtime-programmable serial sequence detector
// Ports:
//   ck        : clock, rising edge
//   reset     : synchronous active-high reset, restores the legacy "111" overlapping detector
//   bus.slave : en/i_vld qualified serial input i, cfg_load/cfg_pat/cfg_len/cfg_ovl config,
//               cnt_clr; outputs o (registered match pulse), match_cnt (saturating), armed
module sdet_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(3'b111),
    parameter int                 DEF_LEN = 3,
    parameter logic               DEF_OVL = 1'b1
) (
    input  logic        ck,
    input  logic        reset,
    sdet_param_if.slave bus
);

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               armed_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic               o_q;
    logic [CNT_W-1:0]   cnt;

    logic               s;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               m;
    logic               len_legal;

    // A config load in the same cycle wins: the offered sample is dropped.
    assign s         = bus.i_vld & bus.en & armed_q & ~bus.cfg_load;
    assign hist_next = {hist[MAX_LEN-2:0], bus.i};
    assign fill_inc  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    assign len_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

    // Only the low len bits take part in the compare; pattern bits above len are don't-care.
    always_comb begin
        len_mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            len_mask[k] = (k < int'(len));
        end
    end

    // The match looks at the history as it will be after this sample shifts in,
    // so o can be registered directly from m with a single cycle of latency.
    assign m = s && (fill_inc >= len) && (((hist_next ^ pat) & len_mask) == '0);

    always_ff @(posedge ck) begin
        if (reset) begin
            pat     <= DEF_PAT;
            len     <= LEN_W'(DEF_LEN);
            ovl     <= DEF_OVL;
            armed_q <= 1'b1;
            hist    <= '0;
            fill    <= '0;
            o_q     <= 1'b0;
            cnt     <= '0;
        end else begin
            o_q <= m;

            if (bus.cfg_load) begin
                pat     <= bus.cfg_pat;
                len     <= bus.cfg_len;
                ovl     <= bus.cfg_ovl;
                armed_q <= len_legal;
                hist    <= '0;
                fill    <= '0;
            end else if (s) begin
                hist <= hist_next;
                // Non-overlap restarts the fill count so the next match needs len fresh bits;
                // the history keeps shifting since stale bits are masked by the fill check.
                fill <= (m && !ovl) ? '0 : fill_inc;
            end

            if (bus.cnt_clr) begin
                cnt <= m ? CNT_W'(1) : '0;
            end else if (m && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.o         = o_q;
    assign bus.match_cnt = cnt;
    assign bus.armed     = armed_q;

endmodule

// File: tb/tb_sdet_param.sv
// tb/tb_sdet_param.sv - scoreboard bench for sdet_param with a bit-queue reference model
module tb_sdet_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic ck = 1'b0;
    logic reset;

    always #5 ck = ~ck;

    sdet_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    sdet_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit o;
        int cnt;
        bit armed;
        int step;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int step_no = 0;

    // Reference model: bits accepted since arming or since the last non-overlap match.
    bit               acc[$];
    bit [MAX_LEN-1:0] r_pat;
    int               r_len;
    bit               r_ovl;
    bit               r_armed;
    int               r_cnt;

    task automatic model_reset();
        r_pat   = MAX_LEN'(3'b111);
        r_len   = 3;
        r_ovl   = 1'b1;
        r_armed = 1'b1;
        r_cnt   = 0;
        acc.delete();
    endtask

    task automatic drive(input bit rst, input bit en, input bit ld, input bit [MAX_LEN-1:0] pat,
                         input int len, input bit ovl, input bit din, input bit vld, input bit clr);
        exp_t e;
        bit   hit;
        reset        = rst;
        bus.en       = en;
        bus.cfg_load = ld;
        bus.cfg_pat  = pat;
        bus.cfg_len  = LEN_W'(len);
        bus.cfg_ovl  = ovl;
        bus.i        = din;
        bus.i_vld    = vld;
        bus.cnt_clr  = clr;
        hit = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (ld) begin
                r_pat   = pat;
                r_len   = len;
                r_ovl   = ovl;
                r_armed = (len >= 1) && (len <= MAX_LEN);
                acc.delete();
            end else if (vld && en && r_armed) begin
                acc.push_back(din);
                if (acc.size() > MAX_LEN) void'(acc.pop_front());
                if (acc.size() >= r_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < r_len; k++)
                        if (acc[acc.size() - 1 - k] != r_pat[k]) hit = 1'b0;
                end
                if (hit && !r_ovl) acc.delete();
            end
            if (clr) r_cnt = hit ? 1 : 0;
            else if (hit && r_cnt < CNT_MAX) r_cnt = r_cnt + 1;
        end
        step_no++;
        e.o     = hit;
        e.cnt   = r_cnt;
        e.armed = r_armed;
        e.step  = step_no;
        exp_q.push_back(e);
        @(negedge ck);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 1, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input bit [MAX_LEN-1:0] pat, input int len, input bit ovl);
        drive(0, 1, 1, pat, len, ovl, 1'b1, 1'b1, 0);
    endtask

    // Sends n bits of v, most significant of those n first.
    task automatic send(input bit [15:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) drive(0, 1, 0, '0, 0, 0, v[k], 1'b1, 0);
    endtask

    task automatic chk(input string name, input int step, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, req);
        end
    endtask

    // Monitor: outputs are registered, so each expectation is due at the negedge after its posedge.
    always @(negedge ck) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("o", e.step, int'(bus.o), int'(e.o));
            chk("match_cnt", e.step, int'(bus.match_cnt), e.cnt);
            chk("armed", e.step, int'(bus.armed), int'(e.armed));
        end
    end

    initial begin
        int r;
        int len;
        // test 1: defaults detect 111
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
        send(16'b111, 3);
        idle(1);
        // test 2: overlapping 11111 -> three pulses
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
        send(16'b11111, 5);
        idle(1);
        // test 3: 1011 non-overlap
        load(8'b1011, 4, 0);
        send(16'b1011011, 7);
        idle(1);
        // test 4: 1011 overlap
        load(8'b1011, 4, 1);
        send(16'b1011011, 7);
        idle(1);
        // test 5: en gap preserves partial match
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
        send(16'b11, 2);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, '0, 0, 0, 0, 1, 0);
        send(16'b1, 1);
        // i_vld gap also holds
        drive(0, 1, 0, '0, 0, 0, 0, 0, 0);
        send(16'b1, 1);
        // non-overlap 111111 -> two pulses
        load(8'b111, 3, 0);
        send(16'b111111, 6);
        // test 6: illegal lengths disarm
        load(8'hFF, 0, 1);
        send(16'hFF, 8);
        load(8'hFF, 9, 1);
        send(16'hFF, 8);
        // cfg_load discards a concurrent sample
        load(8'b11, 2, 1);
        send(16'b1, 1);
        load(8'b11, 2, 1);
        send(16'b11, 2);
        // saturation and clear-with-match
        load(8'b1, 1, 1);
        send(16'hFFF, 12);
        drive(0, 1, 0, '0, 0, 0, 1, 1, 1);
        drive(0, 1, 0, '0, 0, 0, 0, 1, 1);
        // full-length pattern, upper pattern bits ignored for short lengths
        load(8'b1010_0110, 8, 0);
        send(16'b1010_0110_1010_0110, 16);
        load(8'b1111_0010, 3, 1);
        send(16'b0100_1001, 8);
        // reset mid-stream discards partial match
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
        send(16'b11, 2);
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
        send(16'b111, 3);

        // random phase
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
            end else if (r < 4) begin
                if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 15);
                else len = $urandom_range(1, 4);
                drive(0, $urandom_range(0, 1), 1, MAX_LEN'($urandom), len, $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 19) == 0);
            end else begin
                drive(0, $urandom_range(0, 9) != 0, 0, MAX_LEN'($urandom), 0, 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 6) != 0,
                      $urandom_range(0, 29) == 0);
            end
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge ck);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
